dec_mpp_suffix_stream: RTL and testbench

//  Sequential, parametrised MPP-suffix decoder for the VDC-M block decoder. It accepts one left-aligned

---
 rtl/dec_mpp_pkg.sv | 19 +
 rtl/mpp_sample_unpack.sv | 27 ++
 rtl/dec_mpp_suffix_stream.sv | 157 +++++++++++++++
 tb/tb_dec_mpp_suffix_stream.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_mpp_pkg.sv
// Shared sizing, state encoding and residual offset helper for the MPP suffix decoder.
package dec_mpp_pkg;

  localparam int MAX_BITS = 8;
  localparam int OUT_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT
  } state_e;

  // Offset that recentres an unsigned raw code of width bits around zero.
  function automatic int min_code(input logic [3:0] bits);
    if (bits == 4'd0) return 0;
    return -(1 << (int'(bits) - 1));
  endfunction

endpackage

// File: rtl/mpp_sample_unpack.sv
// Splits the top NSAMP*bits of a left-aligned window into NSAMP signed residuals.
module mpp_sample_unpack
  import dec_mpp_pkg::*;
#(
  parameter int NSAMP = 4
) (
  input  logic [NSAMP*MAX_BITS-1:0] win_i,
  input  logic [3:0]                bits_i,
  output logic [NSAMP*OUT_W-1:0]    samples_o,
  output logic [7:0]                grp_w_o
);

  logic [MAX_BITS-1:0] mask;
  logic [MAX_BITS-1:0] raw;

  always_comb begin
    samples_o = '0;
    raw       = '0;
    mask      = MAX_BITS'((32'd1 << bits_i) - 32'd1);
    grp_w_o   = 8'(NSAMP * int'(bits_i));
    for (int i = 0; i < NSAMP; i++) begin
      raw = MAX_BITS'(win_i >> (NSAMP*MAX_BITS - (i+1)*int'(bits_i))) & mask;
      samples_o[OUT_W*(NSAMP-i)-1 -: OUT_W] = OUT_W'(int'(raw) + min_code(bits_i));
    end
  end

endmodule

// File: rtl/dec_mpp_suffix_stream.sv
// MPP suffix decoder: latches one suffix window per block and streams one
// component group of residuals per cycle, returning the unconsumed suffix at the end.
module dec_mpp_suffix_stream
  import dec_mpp_pkg::*;
#(
  parameter int SUF_W    = 128,
  parameter int NSAMP    = 4,
  parameter int MAX_COMP = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             bitDepth,
  input  logic [3:0]             stepSize,
  input  logic [1:0]             num_comp,
  input  logic [SUF_W-1:0]       suffix,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_comp,
  output logic [NSAMP*OUT_W-1:0] out_samples,
  output logic                   out_last,
  output logic [SUF_W-1:0]       suffix_left,
  output logic [7:0]             qres_size,
  output logic                   err
);

  state_e                 state_q, state_d;
  logic [SUF_W-1:0]       sr_q, sr_d;
  logic [3:0]             bits_q, bits_d;
  logic [1:0]             ncomp_q, ncomp_d;
  logic [1:0]             cnt_q, cnt_d;
  logic                   vld_q, vld_d;
  logic                   last_q, last_d;
  logic [1:0]             comp_q, comp_d;
  logic [NSAMP*OUT_W-1:0] samp_q, samp_d;
  logic [SUF_W-1:0]       sleft_q, sleft_d;
  logic [7:0]             qres_q, qres_d;
  logic                   err_q, err_d;

  logic [3:0]             bits_in;
  logic                   illegal;
  logic                   advance;
  logic                   hs_last;
  logic [NSAMP*OUT_W-1:0] unp_samples;
  logic [7:0]             unp_grp_w;

  mpp_sample_unpack #(.NSAMP(NSAMP)) u_unpack (
    .win_i     (sr_q[SUF_W-1 -: NSAMP*MAX_BITS]),
    .bits_i    (bits_q),
    .samples_o (unp_samples),
    .grp_w_o   (unp_grp_w)
  );

  assign bits_in = bitDepth - stepSize;
  assign illegal = (stepSize >= bitDepth) || (bits_in > 4'(MAX_BITS)) ||
                   (num_comp == 2'd0) || (int'(num_comp) > MAX_COMP);
  assign advance = (!vld_q || out_ready) && (cnt_q < ncomp_q);
  assign hs_last = vld_q && out_ready && last_q;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bits_d  = bits_q;
    ncomp_d = ncomp_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    last_d  = last_q;
    comp_d  = comp_q;
    samp_d  = samp_q;
    sleft_d = sleft_q;
    qres_d  = qres_q;
    err_d   = 1'b0;
    if (flush) begin
      state_d = IDLE;
      vld_d   = 1'b0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (illegal) begin
              err_d = 1'b1;
            end else begin
              state_d = LOAD;
              sr_d    = suffix;
              bits_d  = bits_in;
              ncomp_d = num_comp;
              cnt_d   = 2'd0;
            end
          end
        end
        LOAD, EMIT: begin
          if (hs_last) begin
            state_d = IDLE;
            vld_d   = 1'b0;
            last_d  = 1'b0;
          end else if (advance) begin
            state_d = EMIT;
            samp_d  = unp_samples;
            sr_d    = sr_q << unp_grp_w;
            vld_d   = 1'b1;
            comp_d  = cnt_q;
            last_d  = (cnt_q == ncomp_q - 2'd1);
            cnt_d   = cnt_q + 2'd1;
            if (cnt_q == ncomp_q - 2'd1) begin
              sleft_d = sr_q << unp_grp_w;
              qres_d  = 8'(int'(ncomp_q) * NSAMP * int'(bits_q));
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bits_q  <= '0;
      ncomp_q <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      comp_q  <= '0;
      samp_q  <= '0;
      sleft_q <= '0;
      qres_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bits_q  <= bits_d;
      ncomp_q <= ncomp_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      comp_q  <= comp_d;
      samp_q  <= samp_d;
      sleft_q <= sleft_d;
      qres_q  <= qres_d;
      err_q   <= err_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = vld_q;
  assign out_last    = last_q;
  assign out_comp    = comp_q;
  assign out_samples = samp_q;
  assign suffix_left = sleft_q;
  assign qres_size   = qres_q;
  assign err         = err_q;

endmodule

// File: tb/tb_dec_mpp_suffix_stream.sv
// Scoreboard bench for dec_mpp_suffix_stream: stimulus queues expected groups,
// a negedge monitor pops and compares on every output handshake.
module tb_dec_mpp_suffix_stream;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   bitDepth;
  logic [3:0]   stepSize;
  logic [1:0]   num_comp;
  logic [127:0] suffix;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_comp;
  logic [31:0]  out_samples;
  logic         out_last;
  logic [127:0] suffix_left;
  logic [7:0]   qres_size;
  logic         err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]   comp;
    logic [31:0]  samp;
    logic         last;
    logic [127:0] sl;
    logic [7:0]   qres;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [127:0] S1  = {6'd0, 6'd32, 6'd63, 6'd1, 6'd5, 6'd10, 6'd20, 6'd40,
                                  6'd63, 6'd62, 6'd0, 6'd33, 56'hA5A5123456789A};
  localparam logic [127:0] SL1 = {56'hA5A5123456789A, 72'd0};
  localparam logic [127:0] S3  = {48'h0F871234CDEF, 80'h0123456789ABCDEF0011};
  localparam logic [127:0] SL3 = {80'h0123456789ABCDEF0011, 48'd0};
  localparam logic [127:0] S5  = {20'h07E0F, 108'hFEDCBA9876543210FEDCBA98765};
  localparam logic [127:0] SL5 = {108'hFEDCBA9876543210FEDCBA98765, 20'd0};
  localparam logic [127:0] S6  = 128'h112233445566778899AABBCCDDEEFF00;

  dec_mpp_suffix_stream dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .bitDepth    (bitDepth),
    .stepSize    (stepSize),
    .num_comp    (num_comp),
    .suffix      (suffix),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_comp    (out_comp),
    .out_samples (out_samples),
    .out_last    (out_last),
    .suffix_left (suffix_left),
    .qres_size   (qres_size),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] s4(input int a, input int b, input int c, input int d);
    return {a[7:0], b[7:0], c[7:0], d[7:0]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] c, input logic [31:0] s, input logic l,
                      input logic [127:0] sl, input logic [7:0] q);
    exp_t e;
    e.comp = c; e.samp = s; e.last = l; e.sl = sl; e.qres = q;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] bd, input logic [3:0] ss, input logic [1:0] nc,
                      input logic [127:0] suf);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_before_send", in_ready, 1);
    in_valid = 1'b1;
    bitDepth = bd;
    stepSize = ss;
    num_comp = nc;
    suffix   = suf;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(in_ready && !out_valid) && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (!(in_ready && !out_valid)) begin
      errors++;
      $display("FAIL idle_wait: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic push_test1();
    push(2'd0, s4(-32, 0, 31, -31), 1'b0, '0, 8'd0);
    push(2'd1, s4(-27, -22, -12, 8), 1'b0, '0, 8'd0);
    push(2'd2, s4(31, 30, -32, 1), 1'b1, SL1, 8'd72);
  endtask

  // Output monitor: hold-stability while stalled, scoreboard pop on handshake.
  logic        stalled = 1'b0;
  logic [31:0] held_samp;
  logic [1:0]  held_comp;
  logic        held_last;

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled && out_valid) begin
        chk("hold_samples", out_samples, held_samp);
        chk("hold_comp", out_comp, held_comp);
        chk("hold_last", out_last, held_last);
      end
      stalled   = out_valid && !out_ready;
      held_samp = out_samples;
      held_comp = out_comp;
      held_last = out_last;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_group: comp=%0d samples=%0h required no output", out_comp, out_samples);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("group_comp", out_comp, e.comp);
          chk("group_samples", out_samples, e.samp);
          chk("group_last", out_last, e.last);
          if (e.last) begin
            chk("suffix_left", suffix_left, e.sl);
            chk("qres_size", qres_size, e.qres);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] pat;
    logic [3:0] ill_bd [3];
    logic [3:0] ill_ss [3];
    logic [1:0] ill_nc [3];
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    bitDepth = '0; stepSize = '0; num_comp = '0; suffix = '0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err", err, 0);
    chk("rst_out_comp", out_comp, 0);
    chk("rst_out_samples", out_samples, 0);
    chk("rst_suffix_left", suffix_left, 0);
    chk("rst_qres", qres_size, 0);
    tick();
    rst = 1'b0;
    tick();

    // 1: bits=6, three groups, latency T+2
    out_ready = 1'b1;
    push_test1();
    send(4'd8, 4'd2, 2'd3, S1);
    chk("lat_load_cycle", out_valid, 0);
    tick();
    chk("lat_first_valid", out_valid, 1);
    wait_idle();

    // 2: bits=8, all ones, back-to-back
    for (int i = 0; i < 3; i++)
      push(2'(i), s4(127, 127, 127, 127), (i == 2), {32'hFFFFFFFF, 96'd0}, 8'd96);
    send(4'd8, 4'd0, 2'd3, '1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b2b_valid", out_valid, 1);
      chk("b2b_last", out_last, (i == 2));
    end
    tick();
    chk("b2b_done", out_valid, 0);
    wait_idle();

    // 3: stalls 1,0,0,1
    out_ready = 1'b0;
    push(2'd0, s4(-8, 7, 0, -1), 1'b0, '0, 8'd0);
    push(2'd1, s4(-7, -6, -5, -4), 1'b0, '0, 8'd0);
    push(2'd2, s4(4, 5, 6, 7), 1'b1, SL3, 8'd48);
    send(4'd8, 4'd4, 2'd3, S3);
    pat = 5'b11001;
    for (int i = 0; i < 5; i++) begin
      out_ready = pat[i];
      tick();
    end
    out_ready = 1'b1;
    wait_idle();

    // 4: illegal requests
    ill_bd[0] = 4'd8;  ill_ss[0] = 4'd8; ill_nc[0] = 2'd3;
    ill_bd[1] = 4'd12; ill_ss[1] = 4'd2; ill_nc[1] = 2'd1;
    ill_bd[2] = 4'd8;  ill_ss[2] = 4'd2; ill_nc[2] = 2'd0;
    for (int k = 0; k < 3; k++) begin
      send(ill_bd[k], ill_ss[k], ill_nc[k], S1);
      chk("ill_err_pulse", err, 1);
      chk("ill_in_ready", in_ready, 1);
      chk("ill_no_valid", out_valid, 0);
      tick();
      chk("ill_err_clear", err, 0);
      chk("ill_no_valid2", out_valid, 0);
      tick();
    end

    // 5: single group, bits=5
    out_ready = 1'b1;
    push(2'd0, s4(-16, 15, 0, -1), 1'b1, SL5, 8'd20);
    send(4'd7, 4'd2, 2'd1, S5);
    chk("single_load", out_valid, 0);
    tick();
    chk("single_valid", out_valid, 1);
    chk("single_last", out_last, 1);
    chk("single_busy", in_ready, 0);
    tick();
    chk("single_ready_back", in_ready, 1);
    chk("single_done", out_valid, 0);

    // 6a: flush wins over in_valid
    in_valid = 1'b1; flush = 1'b1;
    bitDepth = 4'd8; stepSize = 4'd0; num_comp = 2'd3; suffix = S6;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_blocks_accept", in_ready, 1);
    tick();
    chk("flush_blocks_valid", out_valid, 0);

    // 6b: flush during second group
    out_ready = 1'b1;
    push(2'd0, s4(-111, -94, -77, -60), 1'b0, '0, 8'd0);
    send(4'd8, 4'd0, 2'd3, S6);
    tick();
    tick();
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_last", out_last, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_keeps_suffix_left", suffix_left, SL5);
    chk("flush_keeps_qres", qres_size, 20);

    // 6c: async reset mid-block
    send(4'd8, 4'd0, 2'd3, S6);
    tick();
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_suffix_left", suffix_left, 0);
    chk("rst_mid_qres", qres_size, 0);
    chk("rst_mid_samples", out_samples, 0);
    tick();
    rst = 1'b0;
    tick();

    // 6d: clean decode after reset
    out_ready = 1'b1;
    push_test1();
    send(4'd8, 4'd2, 2'd3, S1);
    wait_idle();
    tick();
    tick();
    chk("queue_empty", 128'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
